// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing the single LITE-16 data RAM port between the CPU (port 0)
// and the debug/DMA loader (port 1), with bounded locked sequences and registered responses.
module ram_arbiter #(
    parameter int DEPTH    = 128,
    parameter int MAX_LOCK = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic        m0_lock,
    input  logic [15:0] m0_addr,
    input  logic [15:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rsp_valid,
    output logic [15:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic        m1_lock,
    input  logic [15:0] m1_addr,
    input  logic [15:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rsp_valid,
    output logic [15:0] m1_rdata,
    output logic        m1_err,
    output logic [15:0] ram_address,
    output logic [15:0] ram_data_in,
    output logic        ram_store,
    output logic        ram_load,
    input  logic [15:0] ram_data_out,
    output logic [1:0]  dbg_state
);
    // Handshake: a port holds req/we/lock/addr/wdata stable until it sees gnt; the access
    // transfers at the posedge where req & gnt, and its response pulses rsp_valid one cycle later.

    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);

    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             m0_rsp_valid_q, m0_rsp_valid_d, m0_err_q, m0_err_d;
    logic             m1_rsp_valid_q, m1_rsp_valid_d, m1_err_q, m1_err_d;
    logic [15:0]      m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

    logic        any_gnt, owned, in_range;
    logic        acc_we, acc_lock;
    logic [15:0] acc_addr, acc_wdata, load_data;
    logic [CNT_W-1:0] cnt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            last_q         <= 1'b1;
            lock_cnt_q     <= '0;
            m0_rsp_valid_q <= 1'b0;
            m0_rdata_q     <= '0;
            m0_err_q       <= 1'b0;
            m1_rsp_valid_q <= 1'b0;
            m1_rdata_q     <= '0;
            m1_err_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_q         <= last_d;
            lock_cnt_q     <= lock_cnt_d;
            m0_rsp_valid_q <= m0_rsp_valid_d;
            m0_rdata_q     <= m0_rdata_d;
            m0_err_q       <= m0_err_d;
            m1_rsp_valid_q <= m1_rsp_valid_d;
            m1_rdata_q     <= m1_rdata_d;
            m1_err_q       <= m1_err_d;
        end
    end

    // Grant and RAM drive; an owner that drops req releases in the same cycle.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (state_q == OWN0 && m0_req) begin
            m0_gnt = 1'b1;
        end else if (state_q == OWN1 && m1_req) begin
            m1_gnt = 1'b1;
        end else if (m0_req && m1_req) begin
            m0_gnt = last_q;
            m1_gnt = ~last_q;
        end else begin
            m0_gnt = m0_req;
            m1_gnt = m1_req;
        end
        any_gnt   = m0_gnt | m1_gnt;
        acc_we    = m1_gnt ? m1_we    : m0_we;
        acc_lock  = m1_gnt ? m1_lock  : m0_lock;
        acc_addr  = m1_gnt ? m1_addr  : m0_addr;
        acc_wdata = m1_gnt ? m1_wdata : m0_wdata;
        in_range  = acc_addr < 16'(DEPTH);
        ram_address = '0;
        ram_data_in = '0;
        ram_store   = 1'b0;
        ram_load    = 1'b0;
        if (any_gnt && in_range) begin
            ram_address = acc_addr;
            ram_data_in = acc_wdata;
            ram_store   = acc_we;
            ram_load    = ~acc_we;
        end
    end

    always_comb begin
        state_d    = IDLE;
        last_d     = last_q;
        lock_cnt_d = '0;
        owned      = (state_q == OWN0 && m0_gnt) || (state_q == OWN1 && m1_gnt);
        cnt_next   = owned ? lock_cnt_q + CNT_W'(1) : CNT_W'(1);
        if (any_gnt) begin
            last_d = m1_gnt;
            // Reaching MAX_LOCK forces a release; last then favours the other port.
            if (acc_lock && cnt_next < MAX_CNT) begin
                state_d    = m1_gnt ? OWN1 : OWN0;
                lock_cnt_d = cnt_next;
            end
        end
    end

    always_comb begin
        load_data      = (in_range && !acc_we) ? ram_data_out : 16'h0000;
        m0_rsp_valid_d = m0_gnt;
        m1_rsp_valid_d = m1_gnt;
        m0_rdata_d     = m0_gnt ? load_data : m0_rdata_q;
        m1_rdata_d     = m1_gnt ? load_data : m1_rdata_q;
        m0_err_d       = m0_gnt ? ~in_range : m0_err_q;
        m1_err_d       = m1_gnt ? ~in_range : m1_err_q;
    end

    assign m0_rsp_valid = m0_rsp_valid_q;
    assign m0_rdata     = m0_rdata_q;
    assign m0_err       = m0_err_q;
    assign m1_rsp_valid = m1_rsp_valid_q;
    assign m1_rdata     = m1_rdata_q;
    assign m1_err       = m1_err_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: spec-level arbitration/memory model feeding per-port expected-response
// queues, a response monitor, directed scenarios and a randomized phase.
module tb_ram_arbiter;
    localparam int DEPTH    = 128;
    localparam int MAX_LOCK = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, we, lk;
    logic [15:0] addr [2];
    logic [15:0] wdata [2];
    logic        m0_gnt, m0_rsp_valid, m0_err, m1_gnt, m1_rsp_valid, m1_err;
    logic [15:0] m0_rdata, m1_rdata;
    logic [15:0] ram_address, ram_data_in, ram_data_out;
    logic        ram_store, ram_load;
    logic [1:0]  dbg_state;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [15:0] ram [DEPTH];
    logic [15:0] model_mem [DEPTH];
    logic [48:0] exp_q0[$], exp_q1[$];   // {cycle, err, rdata}
    logic [33:0] dir_q0[$], dir_q1[$];   // {we, lock, addr, wdata}
    logic [16:0] last0, last1;
    logic [1:0]  granted;
    bit          random_en = 0;
    int          owner, last_port, lock_run;

    ram_arbiter #(.DEPTH(DEPTH), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .rst(rst),
        .m0_req(req[0]), .m0_we(we[0]), .m0_lock(lk[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
        .m0_gnt(m0_gnt), .m0_rsp_valid(m0_rsp_valid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(req[1]), .m1_we(we[1]), .m1_lock(lk[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
        .m1_gnt(m1_gnt), .m1_rsp_valid(m1_rsp_valid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .ram_address(ram_address), .ram_data_in(ram_data_in), .ram_store(ram_store),
        .ram_load(ram_load), .ram_data_out(ram_data_out), .dbg_state(dbg_state)
    );

    // Clock, cycle counter and the RAM the arbiter drives.
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;
    assign ram_data_out = ram[ram_address[6:0]];
    always @(posedge clk) if (ram_store) ram[ram_address[6:0]] <= ram_data_in;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic new_txn(input int p);
        logic [33:0] t;
        bit have;
        have = 0;
        t = '0;
        if (p == 0 && dir_q0.size() > 0) begin
            t = dir_q0.pop_front(); have = 1;
        end else if (p == 1 && dir_q1.size() > 0) begin
            t = dir_q1.pop_front(); have = 1;
        end else if (random_en && $urandom_range(0, 99) < 70) begin
            t[33]    = 1'($urandom_range(0, 1));
            t[32]    = ($urandom_range(0, 3) == 0);
            t[31:16] = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(DEPTH, 65535))
                                                    : 16'($urandom_range(0, DEPTH - 1));
            t[15:0]  = 16'($urandom);
            have = 1;
        end
        req[p]   = have;
        we[p]    = t[33];
        lk[p]    = t[32];
        addr[p]  = t[31:16];
        wdata[p] = t[15:0];
    endtask

    // Driver: a port keeps its request until it is granted, then takes the next one.
    always begin
        @(posedge clk);
        #1;
        if (!rst) begin
            for (int p = 0; p < 2; p++)
                if (!req[p] || granted[p]) new_txn(p);
        end
    end

    // Reference model: who should be granted, what the RAM sees, and what each response holds.
    always @(negedge clk) begin
        int eg;
        logic eerr;
        logic [15:0] erd;
        logic [1:0] egnt;
        if (!rst) begin
            eg = -1;
            if (owner >= 0 && req[owner]) eg = owner;
            else if (req[0] && req[1]) eg = 1 - last_port;
            else if (req[0]) eg = 0;
            else if (req[1]) eg = 1;
            egnt = (eg == 0) ? 2'b01 : (eg == 1) ? 2'b10 : 2'b00;
            check("gnt", 64'({m1_gnt, m0_gnt}), 64'(egnt));
            granted = {m1_gnt, m0_gnt} & req;
            if (eg >= 0) begin
                eerr = (addr[eg] >= 16'(DEPTH));
                erd  = (eerr || we[eg]) ? 16'h0 : model_mem[addr[eg][6:0]];
                if (eerr)
                    check("ram_ctl_err", 64'({ram_store, ram_load}), 64'(0));
                else
                    check("ram_if", 64'({ram_address, ram_data_in, ram_store, ram_load}),
                          64'({addr[eg], wdata[eg], we[eg], ~we[eg]}));
                if (!eerr && we[eg]) model_mem[addr[eg][6:0]] = wdata[eg];
                if (eg == 0) exp_q0.push_back({32'(cyc + 1), eerr, erd});
                else         exp_q1.push_back({32'(cyc + 1), eerr, erd});
                last_port = eg;
                if (lk[eg]) begin
                    if (owner == eg) lock_run++;
                    else begin owner = eg; lock_run = 1; end
                    if (lock_run >= MAX_LOCK) begin owner = -1; lock_run = 0; end
                end else begin
                    owner = -1; lock_run = 0;
                end
            end else begin
                check("ram_idle", 64'({ram_address, ram_data_in, ram_store, ram_load}), 64'(0));
                owner = -1; lock_run = 0;
            end
        end
    end

    // Monitor: pops an expected response whenever a port presents one.
    always @(negedge clk) begin
        logic [48:0] e;
        if (!rst) begin
            if (m0_rsp_valid) begin
                if (exp_q0.size() == 0) check("rsp0_valid", 64'(m0_rsp_valid), 64'(0));
                else begin
                    e = exp_q0.pop_front();
                    check("rsp0_cycle", 64'(cyc), 64'(e[48:17]));
                    check("rsp0_data", 64'({m0_err, m0_rdata}), 64'(e[16:0]));
                    last0 = e[16:0];
                end
            end else begin
                if (exp_q0.size() > 0 && int'(exp_q0[0][48:17]) <= cyc) begin
                    check("rsp0_valid", 64'(m0_rsp_valid), 64'(1));
                    void'(exp_q0.pop_front());
                end
                check("rsp0_hold", 64'({m0_err, m0_rdata}), 64'(last0));
            end
            if (m1_rsp_valid) begin
                if (exp_q1.size() == 0) check("rsp1_valid", 64'(m1_rsp_valid), 64'(0));
                else begin
                    e = exp_q1.pop_front();
                    check("rsp1_cycle", 64'(cyc), 64'(e[48:17]));
                    check("rsp1_data", 64'({m1_err, m1_rdata}), 64'(e[16:0]));
                    last1 = e[16:0];
                end
            end else begin
                if (exp_q1.size() > 0 && int'(exp_q1[0][48:17]) <= cyc) begin
                    check("rsp1_valid", 64'(m1_rsp_valid), 64'(1));
                    void'(exp_q1.pop_front());
                end
                check("rsp1_hold", 64'({m1_err, m1_rdata}), 64'(last1));
            end
        end
    end

    task automatic model_reset();
        exp_q0.delete(); exp_q1.delete(); dir_q0.delete(); dir_q1.delete();
        req = '0; we = '0; lk = '0;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        granted = '0; owner = -1; last_port = 1; lock_run = 0;
        last0 = '0; last1 = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((dir_q0.size() > 0 || dir_q1.size() > 0 || req != 2'b00 ||
                exp_q0.size() > 0 || exp_q1.size() > 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_in_bound", 64'(n < 300), 64'(1));
        @(negedge clk);
    endtask

    initial begin
        int n, bad;
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = 16'($urandom);
            model_mem[i] = ram[i];
        end
        ram[5] = 16'hBEEF;
        model_mem[5] = 16'hBEEF;
        repeat (2) @(posedge clk);
        #2;
        check("reset_m0", 64'({m0_rsp_valid, m0_err, m0_rdata}), 64'(0));
        check("reset_m1", 64'({m1_rsp_valid, m1_err, m1_rdata}), 64'(0));
        #1 rst = 1'b0;

        // Load from the preloaded word.
        dir_q0.push_back({1'b0, 1'b0, 16'd5, 16'h0});
        wait_idle();
        check("t1_rdata", 64'({m0_err, m0_rdata}), 64'({1'b0, 16'hBEEF}));

        // Continuous contention without lock alternates.
        for (int i = 0; i < 4; i++) begin
            dir_q0.push_back({1'b0, 1'b0, 16'(10 + i), 16'h0});
            dir_q1.push_back({1'b0, 1'b0, 16'(20 + i), 16'h0});
        end
        wait_idle();

        // Out-of-range store.
        dir_q1.push_back({1'b1, 1'b0, 16'd200, 16'h1234});
        wait_idle();
        check("t3_err", 64'({m1_err, m1_rdata}), 64'({1'b1, 16'h0}));

        // Locked read-modify-write by m0 while m1 waits, then m1 reads the result.
        dir_q0.push_back({1'b0, 1'b1, 16'd3, 16'h0});
        dir_q0.push_back({1'b1, 1'b0, 16'd3, 16'h5A5A});
        dir_q1.push_back({1'b0, 1'b0, 16'd3, 16'h0});
        wait_idle();
        check("t4_m1_rdata", 64'(m1_rdata), 64'(16'h5A5A));

        // Lock held past MAX_LOCK is forcibly released.
        for (int i = 0; i < 10; i++) dir_q0.push_back({1'b0, 1'b1, 16'(30 + i), 16'h0});
        dir_q1.push_back({1'b0, 1'b0, 16'd50, 16'h0});
        n = 0;
        for (int i = 0; i < 40 && !m1_gnt; i++) begin
            @(negedge clk);
            if (m0_gnt) n++;
        end
        check("t5_lock_run", 64'(n), 64'(MAX_LOCK));
        wait_idle();

        random_en = 1;
        repeat (3000) @(posedge clk);
        random_en = 0;
        wait_idle();

        // Reset asserted while a granted load is waiting for its edge.
        dir_q0.push_back({1'b0, 1'b0, 16'd5, 16'h0});
        n = 0;
        while (!m0_gnt && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t6_gnt_seen", 64'(m0_gnt), 64'(1));
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("t6_async_m0", 64'({m0_rsp_valid, m0_err, m0_rdata}), 64'(0));
        check("t6_async_m1", 64'({m1_rsp_valid, m1_err, m1_rdata}), 64'(0));
        @(posedge clk);
        #1;
        check("t6_no_pulse", 64'({m1_rsp_valid, m0_rsp_valid}), 64'(0));
        #3 rst = 1'b0;
        dir_q0.push_back({1'b0, 1'b0, 16'd1, 16'h0});
        dir_q1.push_back({1'b0, 1'b0, 16'd2, 16'h0});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m0_gnt || m1_gnt) && n < 20);
        check("t6_first_tie", 64'({m1_gnt, m0_gnt}), 64'(2'b01));
        wait_idle();

        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] !== model_mem[i]) bad++;
        check("ram_contents", 64'(bad), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
